cvxif_offload_ctrl: RTL and testbench
=====================================

Name: cvxif_offload_ctrl

Overview:
Sequences offload of coprocessor instructions from the issue stage onto the CV-X-IF coprocessor interface. Tracks outstanding offloaded transactions against the scoreboard's transaction IDs and returns a single writeback stream (result, no-result completion, or illegal-instruction exception) to the scoreboard. Sits between issue_read_operands and the external coprocessor, and is instantiated when the CV-X-IF option is enabled.

Parameters:
XLEN, 32, operand/result width
NR_SB_ENTRIES, 4, scoreboard depth; one tracking slot per transaction ID
TRANS_ID_BITS, $clog2(NR_SB_ENTRIES) = 2, transaction ID width

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, synchronous, active-low
flush_i  in  1  pipeline flush; kill all in-flight offloads
x_valid_i  in  1  issue stage presents an offload instruction
x_ready_o  out  1  controller accepts the instruction
x_instr_i  in  32  instruction word
x_rs1_i  in  XLEN  operand 1
x_rs2_i  in  XLEN  operand 2
x_trans_id_i  in  TRANS_ID_BITS  scoreboard ID
cop_req_valid_o  out  1  request to coprocessor
cop_req_ready_i  in  1  coprocessor takes the request
cop_req_instr_o  out  32  registered instruction
cop_req_rs1_o  out  XLEN  registered rs1
cop_req_rs2_o  out  XLEN  registered rs2
cop_req_id_o  out  TRANS_ID_BITS  registered ID
cop_accept_i  in  1  valid with the request handshake; 1 = instruction recognised
cop_writeback_i  in  1  valid with the request handshake; 1 = result will follow
cop_res_valid_i  in  1  coprocessor result valid
cop_res_ready_o  out  1  controller takes the result
cop_res_id_i  in  TRANS_ID_BITS  result ID
cop_res_data_i  in  XLEN  result data
wb_valid_o  out  1  writeback to scoreboard
wb_trans_id_o  out  TRANS_ID_BITS  writeback ID
wb_data_o  out  XLEN  result, or tval (= instruction) on exception
wb_we_o  out  1  register write required
wb_exception_o  out  1  illegal-instruction exception
outstanding_o  out  TRANS_ID_BITS+1  number of valid tracking slots

Behaviour:
- State: FSM {IDLE, REQ}; per-ID vectors pending[NR_SB_ENTRIES] and killed[NR_SB_ENTRIES]; request register; writeback register.
- Reset (rst_ni=0 at a clk_i edge): FSM=IDLE; pending and killed cleared; all outputs 0, including x_ready_o while rst_ni=0.
- x_ready_o = rst_ni & IDLE & !pending[x_trans_id_i] & !killed[x_trans_id_i] & !flush_i.
- x_valid_i & x_ready_o: capture instruction, operands and ID; go to REQ. cop_req_valid_o=1 from the next cycle. Request fields stay stable until handshake.
- In REQ, cop_req_ready_i=1 completes the handshake; return to IDLE next cycle. Peak throughput is one offload per 2 cycles.
  - accept=1, writeback=1: set pending[id]. No writeback generated now.
  - accept=1, writeback=0: writeback next cycle with we=0, exception=0, data=0.
  - accept=0: writeback next cycle with exception=1, we=0, data=instr.
- cop_res_ready_o = rst_ni & !(REQ & cop_req_ready_i). A local completion in the same cycle takes priority.
- Result handshake:
  - pending[cop_res_id_i]=1: clear it; writeback next cycle with we=1, data=cop_res_data_i, exception=0.
  - killed[cop_res_id_i]=1: clear it; drop the result with no writeback.
  - Neither set: drop silently. This is a protocol error; add an assertion for it.
- Writeback register: wb_valid_o is a 1-cycle pulse per event. At most one event per cycle, guaranteed by the cop_res_ready_o rule.
- Flush (flush_i=1 at an edge):
  - pending bits move into killed (killed |= pending; pending=0).
  - In REQ with no handshake this cycle: drop the request; FSM=IDLE.
  - In REQ with a handshake this cycle: the handshake completes. accept & writeback sets killed[id]; all other outcomes produce no writeback.
  - wb_valid_o=0 next cycle, squashing any writeback that would have been generated.
- ID reuse: an ID with killed=1 stays blocked until its result returns. This prevents late results aliasing a reissued ID.
- outstanding_o = popcount(pending | killed). Max value NR_SB_ENTRIES; no wrap.
- Reset mid-operation: clears everything at the edge. Results returning afterwards are dropped.

Test Plan:
- Reset: hold rst_ni=0 for 3 cycles with x_valid_i=1 -> x_ready_o=0, cop_req_valid_o=0, wb_valid_o=0, outstanding_o=0.
- Offload ID 2, instr 0x0000_000B, rs1=5, rs2=7 -> cop_req_valid_o next cycle with fields held. Ready with accept=1, writeback=1 -> outstanding_o=1. Result id 2 data 0xC -> wb_valid_o=1, id 2, data 0xC, we=1; outstanding_o=0.
- Reject: accept=0 for instr 0xDEAD_BEEF, ID 1 -> wb_valid_o one cycle after handshake, exception=1, data=0xDEADBEEF, we=0.
- Fill: issue IDs 0..3, all accept+writeback, no results -> outstanding_o=4. Reissuing ID 0 -> x_ready_o=0. Results returned out of order (3,1,0,2) -> four writebacks with matching IDs.
- Collision: REQ handshake with accept=0 while cop_res_valid_i=1 -> cop_res_ready_o=0 that cycle. Exception writeback, then result writeback on the following cycle.
- Flush: IDs 0 and 1 outstanding, flush_i=1 -> no writebacks. x_ready_o=0 for ID 0 until its result returns and is dropped; then ID 0 is accepted again. Flush during REQ without ready -> cop_req_valid_o=0 next cycle.

Source files
------------

// File: rtl/cvxif_offload_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cvxif_offload_ctrl
// Brief    : Offloads issue-stage instructions onto the CV-X-IF coprocessor
//            port and merges all completions into one scoreboard writeback.
// Revision : 1.0
// ============================================================================
module cvxif_offload_ctrl #(
    parameter int XLEN          = 32,
    parameter int NR_SB_ENTRIES = 4,
    parameter int TRANS_ID_BITS = $clog2(NR_SB_ENTRIES)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    // issue stage side
    input  logic                     x_valid_i,
    output logic                     x_ready_o,
    input  logic [31:0]              x_instr_i,
    input  logic [XLEN-1:0]          x_rs1_i,
    input  logic [XLEN-1:0]          x_rs2_i,
    input  logic [TRANS_ID_BITS-1:0] x_trans_id_i,
    // coprocessor request
    output logic                     cop_req_valid_o,
    input  logic                     cop_req_ready_i,
    output logic [31:0]              cop_req_instr_o,
    output logic [XLEN-1:0]          cop_req_rs1_o,
    output logic [XLEN-1:0]          cop_req_rs2_o,
    output logic [TRANS_ID_BITS-1:0] cop_req_id_o,
    input  logic                     cop_accept_i,
    input  logic                     cop_writeback_i,
    // coprocessor result
    input  logic                     cop_res_valid_i,
    output logic                     cop_res_ready_o,
    input  logic [TRANS_ID_BITS-1:0] cop_res_id_i,
    input  logic [XLEN-1:0]          cop_res_data_i,
    // scoreboard writeback
    output logic                     wb_valid_o,
    output logic [TRANS_ID_BITS-1:0] wb_trans_id_o,
    output logic [XLEN-1:0]          wb_data_o,
    output logic                     wb_we_o,
    output logic                     wb_exception_o,
    output logic [TRANS_ID_BITS:0]   outstanding_o
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_e;

    state_e                     state_q, state_d;
    logic [NR_SB_ENTRIES-1:0]   pending_q, pending_d;
    logic [NR_SB_ENTRIES-1:0]   killed_q, killed_d;
    logic [31:0]                req_instr_q, req_instr_d;
    logic [XLEN-1:0]            req_rs1_q, req_rs1_d;
    logic [XLEN-1:0]            req_rs2_q, req_rs2_d;
    logic [TRANS_ID_BITS-1:0]   req_id_q, req_id_d;
    logic                       wb_valid_q, wb_valid_d;
    logic [TRANS_ID_BITS-1:0]   wb_id_q, wb_id_d;
    logic [XLEN-1:0]            wb_data_q, wb_data_d;
    logic                       wb_we_q, wb_we_d;
    logic                       wb_exc_q, wb_exc_d;

    logic                       x_ready;
    logic                       res_ready;
    logic                       req_hs;
    logic                       res_hs;
    logic                       res_hit;
    logic [TRANS_ID_BITS:0]     outstanding;

    assign req_hs    = (state_q == REQ) && cop_req_ready_i;
    // A local request completion owns the writeback port this cycle
    assign res_ready = rst_ni && !req_hs;
    assign res_hs    = cop_res_valid_i && res_ready;
    assign res_hit   = res_hs && pending_q[cop_res_id_i];

    // Killed IDs stay blocked so a late result cannot alias a reissue
    assign x_ready = rst_ni && (state_q == IDLE) && !pending_q[x_trans_id_i]
                     && !killed_q[x_trans_id_i] && !flush_i;

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        killed_d    = killed_q;
        req_instr_d = req_instr_q;
        req_rs1_d   = req_rs1_q;
        req_rs2_d   = req_rs2_q;
        req_id_d    = req_id_q;
        wb_valid_d  = 1'b0;
        wb_id_d     = '0;
        wb_data_d   = '0;
        wb_we_d     = 1'b0;
        wb_exc_d    = 1'b0;

        if (res_hs) begin
            if (pending_q[cop_res_id_i]) begin
                pending_d[cop_res_id_i] = 1'b0;
            end else if (killed_q[cop_res_id_i]) begin
                killed_d[cop_res_id_i] = 1'b0;
            end
        end

        if (res_hit) begin
            wb_valid_d = 1'b1;
            wb_id_d    = cop_res_id_i;
            wb_data_d  = cop_res_data_i;
            wb_we_d    = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (x_valid_i && x_ready) begin
                    state_d     = REQ;
                    req_instr_d = x_instr_i;
                    req_rs1_d   = x_rs1_i;
                    req_rs2_d   = x_rs2_i;
                    req_id_d    = x_trans_id_i;
                end
            end
            REQ: begin
                if (req_hs) begin
                    state_d = IDLE;
                    if (cop_accept_i && cop_writeback_i) begin
                        pending_d[req_id_q] = 1'b1;
                    end else begin
                        wb_valid_d = 1'b1;
                        wb_id_d    = req_id_q;
                        wb_exc_d   = !cop_accept_i;
                        wb_data_d  = cop_accept_i ? '0 : XLEN'(req_instr_q);
                    end
                end else if (flush_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Anything still owed a result becomes a result to be discarded
        if (flush_i) begin
            killed_d   = killed_d | pending_d;
            pending_d  = '0;
            wb_valid_d = 1'b0;
            wb_id_d    = '0;
            wb_data_d  = '0;
            wb_we_d    = 1'b0;
            wb_exc_d   = 1'b0;
        end
    end

    always_comb begin
        outstanding = '0;
        for (int i = 0; i < NR_SB_ENTRIES; i++) begin
            outstanding = outstanding
                        + {{TRANS_ID_BITS{1'b0}}, (pending_q[i] | killed_q[i])};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            killed_q    <= '0;
            req_instr_q <= '0;
            req_rs1_q   <= '0;
            req_rs2_q   <= '0;
            req_id_q    <= '0;
            wb_valid_q  <= 1'b0;
            wb_id_q     <= '0;
            wb_data_q   <= '0;
            wb_we_q     <= 1'b0;
            wb_exc_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            killed_q    <= killed_d;
            req_instr_q <= req_instr_d;
            req_rs1_q   <= req_rs1_d;
            req_rs2_q   <= req_rs2_d;
            req_id_q    <= req_id_d;
            wb_valid_q  <= wb_valid_d;
            wb_id_q     <= wb_id_d;
            wb_data_q   <= wb_data_d;
            wb_we_q     <= wb_we_d;
            wb_exc_q    <= wb_exc_d;
        end
    end

    assign x_ready_o       = x_ready;
    assign cop_res_ready_o = res_ready;
    assign cop_req_valid_o = (state_q == REQ);
    assign cop_req_instr_o = req_instr_q;
    assign cop_req_rs1_o   = req_rs1_q;
    assign cop_req_rs2_o   = req_rs2_q;
    assign cop_req_id_o    = req_id_q;
    assign wb_valid_o      = wb_valid_q;
    assign wb_trans_id_o   = wb_id_q;
    assign wb_data_o       = wb_data_q;
    assign wb_we_o         = wb_we_q;
    assign wb_exception_o  = wb_exc_q;
    assign outstanding_o   = outstanding;

    // A result for an ID that is neither pending nor killed is a coprocessor bug
    a_res_id_known: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        res_hs |-> (pending_q[cop_res_id_i] || killed_q[cop_res_id_i])
    );

endmodule
`default_nettype wire

// File: tb/tb_cvxif_offload_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cvxif_offload_ctrl
// Brief    : Vector-table and directed-sequence bench for cvxif_offload_ctrl.
// Revision : 1.0
// ============================================================================
module tb_cvxif_offload_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni, flush_i, x_valid_i, x_ready_o;
    logic [31:0] x_instr_i, x_rs1_i, x_rs2_i;
    logic [1:0]  x_trans_id_i;
    logic        cop_req_valid_o, cop_req_ready_i;
    logic [31:0] cop_req_instr_o, cop_req_rs1_o, cop_req_rs2_o;
    logic [1:0]  cop_req_id_o;
    logic        cop_accept_i, cop_writeback_i;
    logic        cop_res_valid_i, cop_res_ready_o;
    logic [1:0]  cop_res_id_i;
    logic [31:0] cop_res_data_i;
    logic        wb_valid_o;
    logic [1:0]  wb_trans_id_o;
    logic [31:0] wb_data_o;
    logic        wb_we_o, wb_exception_o;
    logic [2:0]  outstanding_o;

    int errors = 0;
    int checks = 0;

    cvxif_offload_ctrl #(.XLEN(32), .NR_SB_ENTRIES(4), .TRANS_ID_BITS(2)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .x_valid_i(x_valid_i), .x_ready_o(x_ready_o), .x_instr_i(x_instr_i),
        .x_rs1_i(x_rs1_i), .x_rs2_i(x_rs2_i), .x_trans_id_i(x_trans_id_i),
        .cop_req_valid_o(cop_req_valid_o), .cop_req_ready_i(cop_req_ready_i),
        .cop_req_instr_o(cop_req_instr_o), .cop_req_rs1_o(cop_req_rs1_o),
        .cop_req_rs2_o(cop_req_rs2_o), .cop_req_id_o(cop_req_id_o),
        .cop_accept_i(cop_accept_i), .cop_writeback_i(cop_writeback_i),
        .cop_res_valid_i(cop_res_valid_i), .cop_res_ready_o(cop_res_ready_o),
        .cop_res_id_i(cop_res_id_i), .cop_res_data_i(cop_res_data_i),
        .wb_valid_o(wb_valid_o), .wb_trans_id_o(wb_trans_id_o),
        .wb_data_o(wb_data_o), .wb_we_o(wb_we_o),
        .wb_exception_o(wb_exception_o), .outstanding_o(outstanding_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string       nm;
        logic        rst_n, flush, xv;
        logic [31:0] instr, rs1, rs2;
        logic [1:0]  tid;
        logic        rr, acc, wbk, resv;
        logic [1:0]  rid;
        logic [31:0] rdata;
        logic        e_xr, e_rr, e_rv, e_wv;
        logic [1:0]  e_wid;
        logic [31:0] e_wd;
        logic        e_we, e_exc;
        logic [2:0]  e_out;
    } vec_t;

    vec_t vecs[$];
    logic [31:0] exp_instr, exp_rs1, exp_rs2;
    logic [1:0]  exp_id;

    function automatic vec_t mk(string nm, logic rst_n, logic flush, logic xv,
            logic [31:0] instr, logic [31:0] rs1, logic [31:0] rs2, logic [1:0] tid,
            logic rr, logic acc, logic wbk, logic resv, logic [1:0] rid, logic [31:0] rdata,
            logic e_xr, logic e_rr, logic e_rv, logic e_wv, logic [1:0] e_wid,
            logic [31:0] e_wd, logic e_we, logic e_exc, logic [2:0] e_out);
        vec_t v;
        v.nm = nm; v.rst_n = rst_n; v.flush = flush; v.xv = xv;
        v.instr = instr; v.rs1 = rs1; v.rs2 = rs2; v.tid = tid;
        v.rr = rr; v.acc = acc; v.wbk = wbk; v.resv = resv; v.rid = rid; v.rdata = rdata;
        v.e_xr = e_xr; v.e_rr = e_rr; v.e_rv = e_rv; v.e_wv = e_wv; v.e_wid = e_wid;
        v.e_wd = e_wd; v.e_we = e_we; v.e_exc = e_exc; v.e_out = e_out;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        rst_ni = 1'b1; flush_i = 1'b0; x_valid_i = 1'b0;
        x_instr_i = '0; x_rs1_i = '0; x_rs2_i = '0; x_trans_id_i = '0;
        cop_req_ready_i = 1'b0; cop_accept_i = 1'b0; cop_writeback_i = 1'b0;
        cop_res_valid_i = 1'b0; cop_res_id_i = '0; cop_res_data_i = '0;
    endtask

    task automatic step(input vec_t v);
        rst_ni = v.rst_n; flush_i = v.flush; x_valid_i = v.xv;
        x_instr_i = v.instr; x_rs1_i = v.rs1; x_rs2_i = v.rs2; x_trans_id_i = v.tid;
        cop_req_ready_i = v.rr; cop_accept_i = v.acc; cop_writeback_i = v.wbk;
        cop_res_valid_i = v.resv; cop_res_id_i = v.rid; cop_res_data_i = v.rdata;
        #1;
        chk({v.nm, ".x_ready"}, 32'(x_ready_o), 32'(v.e_xr));
        chk({v.nm, ".res_ready"}, 32'(cop_res_ready_o), 32'(v.e_rr));
        if (v.xv && v.e_xr) begin
            exp_instr = v.instr; exp_rs1 = v.rs1; exp_rs2 = v.rs2; exp_id = v.tid;
        end
        @(posedge clk_i); #1;
        chk({v.nm, ".req_valid"}, 32'(cop_req_valid_o), 32'(v.e_rv));
        if (v.e_rv) begin
            chk({v.nm, ".req_instr"}, cop_req_instr_o, exp_instr);
            chk({v.nm, ".req_rs1"}, cop_req_rs1_o, exp_rs1);
            chk({v.nm, ".req_rs2"}, cop_req_rs2_o, exp_rs2);
            chk({v.nm, ".req_id"}, 32'(cop_req_id_o), 32'(exp_id));
        end
        chk({v.nm, ".wb_valid"}, 32'(wb_valid_o), 32'(v.e_wv));
        if (v.e_wv) begin
            chk({v.nm, ".wb_id"}, 32'(wb_trans_id_o), 32'(v.e_wid));
            chk({v.nm, ".wb_data"}, wb_data_o, v.e_wd);
            chk({v.nm, ".wb_we"}, 32'(wb_we_o), 32'(v.e_we));
            chk({v.nm, ".wb_exc"}, 32'(wb_exception_o), 32'(v.e_exc));
        end
        chk({v.nm, ".outstanding"}, 32'(outstanding_o), 32'(v.e_out));
    endtask

    // Offload one instruction and complete its request handshake
    task automatic issue(input logic [1:0] id, input logic [31:0] instr,
                         input logic acc, input logic wbk, input logic [2:0] exp_out);
        x_valid_i = 1'b1; x_trans_id_i = id; x_instr_i = instr;
        #1 chk("issue.x_ready", 32'(x_ready_o), 32'd1);
        @(posedge clk_i); #1;
        x_valid_i = 1'b0;
        chk("issue.req_valid", 32'(cop_req_valid_o), 32'd1);
        chk("issue.req_id", 32'(cop_req_id_o), 32'(id));
        cop_req_ready_i = 1'b1; cop_accept_i = acc; cop_writeback_i = wbk;
        @(posedge clk_i); #1;
        cop_req_ready_i = 1'b0; cop_accept_i = 1'b0; cop_writeback_i = 1'b0;
        chk("issue.outstanding", 32'(outstanding_o), 32'(exp_out));
    endtask

    task automatic result(input logic [1:0] id, input logic [31:0] data);
        cop_res_valid_i = 1'b1; cop_res_id_i = id; cop_res_data_i = data;
        #1 chk("result.res_ready", 32'(cop_res_ready_o), 32'd1);
        @(posedge clk_i); #1;
        cop_res_valid_i = 1'b0;
    endtask

    task automatic probe_ready(input string nm, input logic [1:0] id, input logic exp);
        x_valid_i = 1'b1; x_trans_id_i = id;
        #1 chk(nm, 32'(x_ready_o), 32'(exp));
        x_valid_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] order [4];
        idle_inputs();
        //             name       rst fl xv instr          rs1 rs2 tid rr ac wb rv rid rdata     xr rr rv wv wid wd            we ex out
        vecs.push_back(mk("rst0",    0, 0, 1, 32'h0,        0,  0,  0,  0, 0, 0, 0, 0, 32'h0,   0, 0, 0, 0, 0, 32'h0,        0, 0, 0));
        vecs.push_back(mk("rst1",    0, 0, 1, 32'h0,        0,  0,  0,  0, 0, 0, 0, 0, 32'h0,   0, 0, 0, 0, 0, 32'h0,        0, 0, 0));
        vecs.push_back(mk("rst2",    0, 0, 1, 32'h0,        0,  0,  0,  0, 0, 0, 0, 0, 32'h0,   0, 0, 0, 0, 0, 32'h0,        0, 0, 0));
        vecs.push_back(mk("a_issue", 1, 0, 1, 32'hB,        5,  7,  2,  0, 0, 0, 0, 0, 32'h0,   1, 1, 1, 0, 0, 32'h0,        0, 0, 0));
        vecs.push_back(mk("a_hold",  1, 0, 0, 32'h0,        0,  0,  0,  0, 0, 0, 0, 0, 32'h0,   0, 1, 1, 0, 0, 32'h0,        0, 0, 0));
        vecs.push_back(mk("a_hs",    1, 0, 0, 32'h0,        0,  0,  0,  1, 1, 1, 0, 0, 32'h0,   0, 0, 0, 0, 0, 32'h0,        0, 0, 1));
        vecs.push_back(mk("a_res",   1, 0, 0, 32'h0,        0,  0,  0,  0, 0, 0, 1, 2, 32'hC,   1, 1, 0, 1, 2, 32'hC,        1, 0, 0));
        vecs.push_back(mk("b_issue", 1, 0, 1, 32'hDEADBEEF, 0,  0,  1,  0, 0, 0, 0, 0, 32'h0,   1, 1, 1, 0, 0, 32'h0,        0, 0, 0));
        vecs.push_back(mk("b_rej",   1, 0, 0, 32'h0,        0,  0,  0,  1, 0, 0, 0, 0, 32'h0,   0, 0, 0, 1, 1, 32'hDEADBEEF, 0, 1, 0));
        vecs.push_back(mk("b_idle",  1, 0, 0, 32'h0,        0,  0,  0,  0, 0, 0, 0, 0, 32'h0,   1, 1, 0, 0, 0, 32'h0,        0, 0, 0));
        vecs.push_back(mk("c_issue", 1, 0, 1, 32'h1234,     1,  2,  3,  0, 0, 0, 0, 0, 32'h0,   1, 1, 1, 0, 0, 32'h0,        0, 0, 0));
        vecs.push_back(mk("c_nowb",  1, 0, 0, 32'h0,        0,  0,  0,  1, 1, 0, 0, 0, 32'h0,   0, 0, 0, 1, 3, 32'h0,        0, 0, 0));
        vecs.push_back(mk("d_iss0",  1, 0, 1, 32'h100,      0,  0,  0,  0, 0, 0, 0, 0, 32'h0,   1, 1, 1, 0, 0, 32'h0,        0, 0, 0));
        vecs.push_back(mk("d_hs0",   1, 0, 0, 32'h0,        0,  0,  0,  1, 1, 1, 0, 0, 32'h0,   0, 0, 0, 0, 0, 32'h0,        0, 0, 1));
        vecs.push_back(mk("d_iss1",  1, 0, 1, 32'hBAD,      0,  0,  1,  0, 0, 0, 0, 0, 32'h0,   1, 1, 1, 0, 0, 32'h0,        0, 0, 1));
        vecs.push_back(mk("d_coll",  1, 0, 0, 32'h0,        0,  0,  0,  1, 0, 0, 1, 0, 32'h55,  0, 0, 0, 1, 1, 32'hBAD,      0, 1, 1));
        vecs.push_back(mk("d_res",   1, 0, 0, 32'h0,        0,  0,  0,  0, 0, 0, 1, 0, 32'h55,  0, 1, 0, 1, 0, 32'h55,       1, 0, 0));
        vecs.push_back(mk("d_idle",  1, 0, 0, 32'h0,        0,  0,  0,  0, 0, 0, 0, 0, 32'h0,   1, 1, 0, 0, 0, 32'h0,        0, 0, 0));

        foreach (vecs[i]) step(vecs[i]);
        idle_inputs();

        // Fill every slot, then drain out of order
        for (int i = 0; i < 4; i++) issue(2'(i), 32'h200 + i, 1'b1, 1'b1, 3'(i + 1));
        probe_ready("fill.reissue_blocked", 2'd0, 1'b0);
        order[0] = 2'd3; order[1] = 2'd1; order[2] = 2'd0; order[3] = 2'd2;
        for (int k = 0; k < 4; k++) begin
            result(order[k], 32'h300 + 32'(order[k]));
            chk("fill.wb_valid", 32'(wb_valid_o), 32'd1);
            chk("fill.wb_id", 32'(wb_trans_id_o), 32'(order[k]));
            chk("fill.wb_data", wb_data_o, 32'h300 + 32'(order[k]));
            chk("fill.wb_we", 32'(wb_we_o), 32'd1);
            chk("fill.outstanding", 32'(outstanding_o), 32'(3 - k));
        end
        @(posedge clk_i); #1;
        chk("fill.wb_pulse", 32'(wb_valid_o), 32'd0);

        // Flush with two outstanding: results must be swallowed, IDs blocked
        issue(2'd0, 32'h400, 1'b1, 1'b1, 3'd1);
        issue(2'd1, 32'h401, 1'b1, 1'b1, 3'd2);
        flush_i = 1'b1;
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        chk("flush.wb_valid", 32'(wb_valid_o), 32'd0);
        chk("flush.outstanding", 32'(outstanding_o), 32'd2);
        probe_ready("flush.id0_blocked", 2'd0, 1'b0);
        result(2'd1, 32'h77);
        chk("flush.drop1_wb", 32'(wb_valid_o), 32'd0);
        chk("flush.drop1_out", 32'(outstanding_o), 32'd1);
        probe_ready("flush.id0_still_blocked", 2'd0, 1'b0);
        result(2'd0, 32'h88);
        chk("flush.drop0_wb", 32'(wb_valid_o), 32'd0);
        chk("flush.drop0_out", 32'(outstanding_o), 32'd0);
        issue(2'd0, 32'h402, 1'b1, 1'b1, 3'd1);
        result(2'd0, 32'h99);
        chk("reuse.wb_valid", 32'(wb_valid_o), 32'd1);
        chk("reuse.wb_data", wb_data_o, 32'h99);

        // Flush in REQ without a handshake drops the request
        x_valid_i = 1'b1; x_trans_id_i = 2'd2; x_instr_i = 32'h500;
        @(posedge clk_i); #1;
        x_valid_i = 1'b0;
        chk("flreq.req_valid_before", 32'(cop_req_valid_o), 32'd1);
        flush_i = 1'b1;
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        chk("flreq.req_valid", 32'(cop_req_valid_o), 32'd0);
        chk("flreq.wb_valid", 32'(wb_valid_o), 32'd0);
        chk("flreq.outstanding", 32'(outstanding_o), 32'd0);

        // Flush coinciding with a reject handshake squashes the exception
        x_valid_i = 1'b1; x_trans_id_i = 2'd2; x_instr_i = 32'h501;
        @(posedge clk_i); #1;
        x_valid_i = 1'b0;
        cop_req_ready_i = 1'b1; cop_accept_i = 1'b0; flush_i = 1'b1;
        @(posedge clk_i); #1;
        idle_inputs();
        chk("flrej.wb_valid", 32'(wb_valid_o), 32'd0);
        chk("flrej.req_valid", 32'(cop_req_valid_o), 32'd0);

        // Flush coinciding with accept+writeback kills that ID directly
        x_valid_i = 1'b1; x_trans_id_i = 2'd3; x_instr_i = 32'h502;
        @(posedge clk_i); #1;
        x_valid_i = 1'b0;
        cop_req_ready_i = 1'b1; cop_accept_i = 1'b1; cop_writeback_i = 1'b1; flush_i = 1'b1;
        @(posedge clk_i); #1;
        idle_inputs();
        chk("flacc.wb_valid", 32'(wb_valid_o), 32'd0);
        chk("flacc.outstanding", 32'(outstanding_o), 32'd1);
        probe_ready("flacc.id3_blocked", 2'd3, 1'b0);
        result(2'd3, 32'hAA);
        chk("flacc.drop_wb", 32'(wb_valid_o), 32'd0);
        chk("flacc.drop_out", 32'(outstanding_o), 32'd0);
        probe_ready("flacc.id3_free", 2'd3, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
